// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared constants and mux select encodings for the bypassed register file.
//   DW_DEF / AW_DEF : default data and address widths.
//   src_sel_e / dst_sel_e : select encodings for the srcd / dstd read muxes.
//   src_sel() / dst_sel() : priority decode of the bypass conditions.
package regfile_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 6;

  typedef enum logic [1:0] {
    SRC_SEL_REG    = 2'd0,
    SRC_SEL_DST_WD = 2'd1,
    SRC_SEL_SRC_WD = 2'd2,
    SRC_SEL_LOC    = 2'd3
  } src_sel_e;

  typedef enum logic [1:0] {
    DST_SEL_REG    = 2'd0,
    DST_SEL_SRC_WD = 2'd1,
    DST_SEL_DST_WD = 2'd2
  } dst_sel_e;

  // Source read: local override, then own-port write, then the other
  // port's write to the same address, then stored contents.
  function automatic src_sel_e src_sel(input logic locden,
                                       input logic srcwen_n,
                                       input logic dstwen_n,
                                       input logic addr_eq);
    if (locden)                  return SRC_SEL_LOC;
    else if (!srcwen_n)          return SRC_SEL_SRC_WD;
    else if (!dstwen_n && addr_eq) return SRC_SEL_DST_WD;
    else                         return SRC_SEL_REG;
  endfunction

  // Destination read: own-port write, then the other port's write to the
  // same address, then stored contents.
  function automatic dst_sel_e dst_sel(input logic srcwen_n,
                                       input logic dstwen_n,
                                       input logic addr_eq);
    if (!dstwen_n)               return DST_SEL_DST_WD;
    else if (!srcwen_n && addr_eq) return DST_SEL_SRC_WD;
    else                         return DST_SEL_REG;
  endfunction

endpackage

// File: rtl/regfile_ram.sv
// regfile_ram
//   2-read / 2-write register array, 2^AW entries of DW bits, no reset.
//   Ports:
//     i_sys_clk        clock; writes on its rising edge when i_ce=1
//     i_ce             write qualifier
//     i_wa_en/addr/data  write port A (source port)
//     i_wb_en/addr/data  write port B (destination port); wins on collision
//     i_ra_addr/o_ra_data, i_rb_addr/o_rb_data  asynchronous read ports
module regfile_ram
  import regfile_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          i_sys_clk,
  input  logic          i_ce,
  input  logic          i_wa_en,
  input  logic [AW-1:0] i_wa_addr,
  input  logic [DW-1:0] i_wa_data,
  input  logic          i_wb_en,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [DW-1:0] i_wb_data,
  input  logic [AW-1:0] i_ra_addr,
  output logic [DW-1:0] o_ra_data,
  input  logic [AW-1:0] i_rb_addr,
  output logic [DW-1:0] o_rb_data
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] r_mem [DEPTH];

  // Port B is written last so it overrides port A on an address collision.
  always_ff @(posedge i_sys_clk) begin
    if (i_ce) begin
      if (i_wa_en) r_mem[i_wa_addr] <= i_wa_data;
      if (i_wb_en) r_mem[i_wb_addr] <= i_wb_data;
    end
  end

  assign o_ra_data = r_mem[i_ra_addr];
  assign o_rb_data = r_mem[i_rb_addr];

endmodule

// File: rtl/regfile_bypass.sv
// regfile_bypass
//   Two-port register file with write-through bypass, a one-stage read
//   pipeline and a load scoreboard.
//   Ports:
//     sys_clk, reset_n (async, active-low), ce (advance strobe)
//     srca/srcwen_n/srcwd, dsta/dstwen_n/dstwd : the two access ports
//     locden/locsrc     : local-data override for the source read
//     exe               : load enable for srcdp
//     mtx_dover/mem_data: memory override for dstdp
//     ld_issue/ld_addr, ld_done/ld_done_addr : scoreboard set / clear
//     srcd, dstd        : combinational bypassed reads
//     srcdp, dstdp      : pipelined reads
//     src_busy, dst_busy, any_pending : scoreboard hazard flags
module regfile_bypass
  import regfile_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          sys_clk,
  input  logic          reset_n,
  input  logic          ce,
  input  logic [AW-1:0] srca,
  input  logic          srcwen_n,
  input  logic [DW-1:0] srcwd,
  input  logic [AW-1:0] dsta,
  input  logic          dstwen_n,
  input  logic [DW-1:0] dstwd,
  input  logic          locden,
  input  logic [DW-1:0] locsrc,
  input  logic          exe,
  input  logic          mtx_dover,
  input  logic [DW-1:0] mem_data,
  input  logic          ld_issue,
  input  logic [AW-1:0] ld_addr,
  input  logic          ld_done,
  input  logic [AW-1:0] ld_done_addr,
  output logic [DW-1:0] srcd,
  output logic [DW-1:0] dstd,
  output logic [DW-1:0] srcdp,
  output logic [DW-1:0] dstdp,
  output logic          src_busy,
  output logic          dst_busy,
  output logic          any_pending
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0]    w_rd_src;
  logic [DW-1:0]    w_rd_dst;
  logic             w_addr_eq;
  src_sel_e         w_src_sel;
  dst_sel_e         w_dst_sel;
  logic [DEPTH-1:0] w_pending_next;

  logic [DW-1:0]    r_srcdp;
  logic [DW-1:0]    r_dstdpt;
  logic             r_mtx_doverp;
  logic [DEPTH-1:0] r_pending;

  regfile_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .i_sys_clk (sys_clk),
    .i_ce      (ce),
    .i_wa_en   (~srcwen_n),
    .i_wa_addr (srca),
    .i_wa_data (srcwd),
    .i_wb_en   (~dstwen_n),
    .i_wb_addr (dsta),
    .i_wb_data (dstwd),
    .i_ra_addr (srca),
    .o_ra_data (w_rd_src),
    .i_rb_addr (dsta),
    .o_rb_data (w_rd_dst)
  );

  assign w_addr_eq = (srca == dsta);
  assign w_src_sel = src_sel(locden, srcwen_n, dstwen_n, w_addr_eq);
  assign w_dst_sel = dst_sel(srcwen_n, dstwen_n, w_addr_eq);

  always_comb begin
    srcd = w_rd_src;
    case (w_src_sel)
      SRC_SEL_LOC:    srcd = locsrc;
      SRC_SEL_SRC_WD: srcd = srcwd;
      SRC_SEL_DST_WD: srcd = dstwd;
      default:        srcd = w_rd_src;
    endcase
  end

  always_comb begin
    dstd = w_rd_dst;
    case (w_dst_sel)
      DST_SEL_DST_WD: dstd = dstwd;
      DST_SEL_SRC_WD: dstd = srcwd;
      default:        dstd = w_rd_dst;
    endcase
  end

  // Per-entry scoreboard update; a set overrides a same-cycle clear.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
      assign w_pending_next[gi] = (ld_issue && (ld_addr == AW'(gi))) ||
                                  (r_pending[gi] && !(ld_done && (ld_done_addr == AW'(gi))));
    end
  endgenerate

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_srcdp      <= '0;
      r_dstdpt     <= '0;
      r_mtx_doverp <= 1'b0;
      r_pending    <= '0;
    end else if (ce) begin
      if (exe) r_srcdp <= srcd;
      r_dstdpt     <= dstd;
      r_mtx_doverp <= mtx_dover;
      r_pending    <= w_pending_next;
    end
  end

  assign srcdp       = r_srcdp;
  assign dstdp       = r_mtx_doverp ? mem_data : r_dstdpt;
  assign src_busy    = r_pending[srca] & ~locden;
  assign dst_busy    = r_pending[dsta];
  assign any_pending = |r_pending;

endmodule

// File: tb/tb_regfile_bypass.sv
// tb_regfile_bypass
//   Directed stimulus against regfile_bypass. A behavioural model tracks the
//   register contents, pipelined values and pending set; one compare process
//   checks every output on each falling clock edge, and "pin" slots carry
//   hand-computed literal expectations checked by the same process.
module tb_regfile_bypass;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int DEPTH = 64;

  logic          sys_clk;
  logic          reset_n;
  logic          ce;
  logic [AW-1:0] srca;
  logic          srcwen_n;
  logic [DW-1:0] srcwd;
  logic [AW-1:0] dsta;
  logic          dstwen_n;
  logic [DW-1:0] dstwd;
  logic          locden;
  logic [DW-1:0] locsrc;
  logic          exe;
  logic          mtx_dover;
  logic [DW-1:0] mem_data;
  logic          ld_issue;
  logic [AW-1:0] ld_addr;
  logic          ld_done;
  logic [AW-1:0] ld_done_addr;
  logic [DW-1:0] srcd;
  logic [DW-1:0] dstd;
  logic [DW-1:0] srcdp;
  logic [DW-1:0] dstdp;
  logic          src_busy;
  logic          dst_busy;
  logic          any_pending;

  regfile_bypass #(.DW(DW), .AW(AW)) dut (
    .sys_clk      (sys_clk),
    .reset_n      (reset_n),
    .ce           (ce),
    .srca         (srca),
    .srcwen_n     (srcwen_n),
    .srcwd        (srcwd),
    .dsta         (dsta),
    .dstwen_n     (dstwen_n),
    .dstwd        (dstwd),
    .locden       (locden),
    .locsrc       (locsrc),
    .exe          (exe),
    .mtx_dover    (mtx_dover),
    .mem_data     (mem_data),
    .ld_issue     (ld_issue),
    .ld_addr      (ld_addr),
    .ld_done      (ld_done),
    .ld_done_addr (ld_done_addr),
    .srcd         (srcd),
    .dstd         (dstd),
    .srcdp        (srcdp),
    .dstdp        (dstdp),
    .src_busy     (src_busy),
    .dst_busy     (dst_busy),
    .any_pending  (any_pending)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // ---------------- behavioural model ----------------
  logic [DW-1:0]    m_reg [DEPTH];
  logic [DW-1:0]    m_srcdp;
  logic [DW-1:0]    m_dstdpt;
  logic             m_doverp;
  logic [DEPTH-1:0] m_pend;

  function automatic logic [DW-1:0] exp_srcd();
    if (locden)                            return locsrc;
    if (!srcwen_n)                         return srcwd;
    if (!dstwen_n && (srca == dsta))       return dstwd;
    return m_reg[srca];
  endfunction

  function automatic logic [DW-1:0] exp_dstd();
    if (!dstwen_n)                         return dstwd;
    if (!srcwen_n && (srca == dsta))       return srcwd;
    return m_reg[dsta];
  endfunction

  always @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      m_srcdp  <= '0;
      m_dstdpt <= '0;
      m_doverp <= 1'b0;
      m_pend   <= '0;
    end else if (ce) begin
      if (!srcwen_n) m_reg[srca] <= srcwd;
      if (!dstwen_n) m_reg[dsta] <= dstwd;
      if (exe) m_srcdp <= exp_srcd();
      m_dstdpt <= exp_dstd();
      m_doverp <= mtx_dover;
      if (ld_done)  m_pend[ld_done_addr] <= 1'b0;
      if (ld_issue) m_pend[ld_addr]      <= 1'b1;
    end
  end

  // ---------------- compare process ----------------
  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Pin slots: 0 srcd, 1 dstd, 2 srcdp, 3 dstdp, 4 src_busy, 5 dst_busy, 6 any_pending
  bit            pin_on  [2];
  int            pin_id  [2];
  logic [DW-1:0] pin_exp [2];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge sys_clk) begin
    if (cmp_en) begin
      chk("srcd", srcd, exp_srcd());
      chk("dstd", dstd, exp_dstd());
      chk("srcdp", srcdp, m_srcdp);
      chk("dstdp", dstdp, m_doverp ? mem_data : m_dstdpt);
      chk("src_busy", {31'b0, src_busy}, {31'b0, m_pend[srca] && !locden});
      chk("dst_busy", {31'b0, dst_busy}, {31'b0, m_pend[dsta]});
      chk("any_pending", {31'b0, any_pending}, {31'b0, m_pend != '0});
    end
    for (int s = 0; s < 2; s++) begin
      if (pin_on[s]) begin
        case (pin_id[s])
          0: begin chk("pin_srcd", srcd, pin_exp[s]);   $display("pin srcd=%h t=%0t", srcd, $time); end
          1: begin chk("pin_dstd", dstd, pin_exp[s]);   $display("pin dstd=%h t=%0t", dstd, $time); end
          2: begin chk("pin_srcdp", srcdp, pin_exp[s]); $display("pin srcdp=%h t=%0t", srcdp, $time); end
          3: begin chk("pin_dstdp", dstdp, pin_exp[s]); $display("pin dstdp=%h t=%0t", dstdp, $time); end
          4: begin chk("pin_src_busy", {31'b0, src_busy}, pin_exp[s]); $display("pin src_busy=%0d t=%0t", src_busy, $time); end
          5: begin chk("pin_dst_busy", {31'b0, dst_busy}, pin_exp[s]); $display("pin dst_busy=%0d t=%0t", dst_busy, $time); end
          default: begin chk("pin_any_pending", {31'b0, any_pending}, pin_exp[s]); $display("pin any_pending=%0d t=%0t", any_pending, $time); end
        endcase
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [DW-1:0] fill_val(input int i);
    return 32'hA500_0000 ^ (i * 32'h0101_0101);
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
    pin_on[0] = 1'b0;
    pin_on[1] = 1'b0;
  endtask

  task automatic pin(input int slot, input int id, input logic [DW-1:0] v);
    pin_id[slot]  = id;
    pin_exp[slot] = v;
    pin_on[slot]  = 1'b1;
  endtask

  task automatic idle();
    ce = 1'b1; srcwen_n = 1'b1; dstwen_n = 1'b1; locden = 1'b0; exe = 1'b0;
    mtx_dover = 1'b0; ld_issue = 1'b0; ld_done = 1'b0;
  endtask

  initial begin
    pin_on[0] = 1'b0; pin_on[1] = 1'b0;
    reset_n = 1'b0;
    idle();
    ce = 1'b0;
    srca = '0; dsta = '0; srcwd = '0; dstwd = '0; locsrc = '0;
    mem_data = '0; ld_addr = '0; ld_done_addr = '0;
    repeat (2) tick();

    // Reset values
    pin(0, 2, 32'h0); pin(1, 6, 32'h0); tick();
    pin(0, 3, 32'h0); pin(1, 4, 32'h0); tick();
    pin(0, 5, 32'h0); tick();
    reset_n = 1'b1;
    tick();

    // Fill every register with a known value through the dst port
    ce = 1'b1;
    cmp_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      dsta = AW'(i); srca = AW'(i); dstwen_n = 1'b0; dstwd = fill_val(i);
      tick();
    end
    idle();

    // Write via dst, read back via src next cycle
    dsta = 6'd5; dstwd = 32'h1234_5678; dstwen_n = 1'b0; srca = 6'd0;
    tick();
    idle(); srca = 6'd5;
    pin(0, 0, 32'h1234_5678); tick();

    // Same-cycle dst-to-src bypass, then local override
    dsta = 6'd3; dstwen_n = 1'b0; dstwd = 32'hAAAA_0000; srca = 6'd3;
    pin(0, 0, 32'hAAAA_0000); pin(1, 1, 32'hAAAA_0000); tick();
    locden = 1'b1; locsrc = 32'h0000_0055;
    pin(0, 0, 32'h0000_0055); tick();
    idle();

    // Both ports write address 7: dst wins in the array
    srca = 6'd7; dsta = 6'd7; srcwen_n = 1'b0; dstwen_n = 1'b0;
    srcwd = 32'h1; dstwd = 32'h2;
    pin(0, 1, 32'h2); pin(1, 0, 32'h1); tick();
    idle(); srca = 6'd7; dsta = 6'd7;
    pin(0, 0, 32'h2); pin(1, 1, 32'h2); tick();

    // srcdp load, then hold over three ce cycles with exe=0
    srca = 6'd5; exe = 1'b1;
    tick();
    exe = 1'b0; srca = 6'd3;
    for (int k = 0; k < 4; k++) begin
      pin(0, 2, 32'h1234_5678); tick();
    end
    // Memory override of dstdp
    mtx_dover = 1'b1; mem_data = 32'h0000_DEAD;
    tick();
    mtx_dover = 1'b0;
    pin(0, 3, 32'h0000_DEAD); tick();
    mem_data = 32'h0000_BEEF;
    tick();

    // ce=0 ignores writes, loads and scoreboard requests
    ce = 1'b0;
    srca = 6'd4; dsta = 6'd4; srcwen_n = 1'b0; dstwen_n = 1'b0;
    srcwd = 32'h0BAD; dstwd = 32'h0BAD; ld_issue = 1'b1; ld_addr = 6'd2;
    exe = 1'b1; locden = 1'b1; locsrc = 32'h77;
    tick();
    idle(); srca = 6'd4; dsta = 6'd4;
    pin(0, 0, fill_val(4)); pin(1, 6, 32'h0); tick();
    pin(0, 2, 32'h1234_5678); tick();

    // Scoreboard set / same-cycle set+clear / clear
    ld_issue = 1'b1; ld_addr = 6'd9;
    tick();
    idle(); dsta = 6'd9;
    pin(0, 5, 32'h1); pin(1, 6, 32'h1); tick();
    ld_issue = 1'b1; ld_done = 1'b1; ld_addr = 6'd9; ld_done_addr = 6'd9;
    tick();
    idle(); dsta = 6'd9;
    pin(0, 5, 32'h1); tick();
    ld_done = 1'b1; ld_done_addr = 6'd9;
    tick();
    idle(); dsta = 6'd9;
    pin(0, 5, 32'h0); pin(1, 6, 32'h0); tick();

    // locden masks src_busy
    ld_issue = 1'b1; ld_addr = 6'd10;
    tick();
    idle(); srca = 6'd10;
    pin(0, 4, 32'h1); tick();
    locden = 1'b1; locsrc = 32'h1;
    pin(0, 4, 32'h0); tick();
    locden = 1'b0; ld_done = 1'b1; ld_done_addr = 6'd10;
    tick();
    idle();

    // Four pending entries and srcdp all-ones, then asynchronous reset
    for (int a = 1; a <= 4; a++) begin
      ld_issue = 1'b1; ld_addr = AW'(a);
      if (a == 4) begin
        locden = 1'b1; locsrc = 32'hFFFF_FFFF; exe = 1'b1;
      end
      tick();
    end
    idle();
    pin(0, 2, 32'hFFFF_FFFF); pin(1, 6, 32'h1); tick();
    pin(0, 6, 32'h0); pin(1, 2, 32'h0);
    #2 reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // A late ld_done for a dropped entry has no effect; new issues still work
    ld_done = 1'b1; ld_done_addr = 6'd1;
    tick();
    idle(); srca = 6'd1;
    pin(0, 6, 32'h0); pin(1, 4, 32'h0); tick();
    ld_issue = 1'b1; ld_addr = 6'd2;
    tick();
    idle(); srca = 6'd2;
    pin(0, 4, 32'h1); tick();

    cmp_en = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_bypass.md
REGFILE_BYPASS -- requirements
Module: regfile_bypass

Interface
REQ-001 SHALL have parameter DW, default 32, meaning the data width of every data port and register.
REQ-002 SHALL have parameter AW, default 6, meaning the register address width; depth is 2^AW.
REQ-003 SHALL have port sys_clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  in  1  the reset, asynchronous and active-low.
REQ-005 SHALL have port ce  in  1  the pipeline advance strobe; writes and pipeline registers update only on sys_clk edges with ce=1.
REQ-006 SHALL have ports srca  in  AW, srcwen_n  in  1, srcwd  in  DW, which are the source port address, its active-low write enable and its write data.
REQ-007 SHALL have ports dsta  in  AW, dstwen_n  in  1, dstwd  in  DW, which are the destination port address, its active-low write enable and its write data.
REQ-008 SHALL have ports locden  in  1, locsrc  in  DW, which are the local-data override select and its value.
REQ-009 SHALL have ports exe  in  1, mtx_dover  in  1, mem_data  in  DW, which are the source-pipe load enable, the dest-pipe memory override and the memory data.
REQ-010 SHALL have ports ld_issue  in  1, ld_addr  in  AW, ld_done  in  1, ld_done_addr  in  AW, which are the scoreboard set and clear requests.
REQ-011 SHALL have outputs srcd  DW, dstd  DW (combinational reads) and srcdp  DW, dstdp  DW (pipelined reads).
REQ-012 SHALL have outputs src_busy  1, dst_busy  1, any_pending  1, which are the scoreboard hazard flags.

Function
REQ-013 SHALL write srcwd to reg[srca] on ce when srcwen_n=0, and dstwd to reg[dsta] on ce when dstwen_n=0.
REQ-014 SHALL, when both ports write the same address in one ce cycle, store dstwd (the dst port wins).
REQ-015 SHALL select srcd in priority order: locden=1 gives locsrc; otherwise srcwen_n=0 gives srcwd; otherwise dstwen_n=0 with srca==dsta gives dstwd; otherwise reg[srca].
REQ-016 SHALL select dstd in priority order: dstwen_n=0 gives dstwd; otherwise srcwen_n=0 with srca==dsta gives srcwd; otherwise reg[dsta].
REQ-017 SHALL load srcdp with srcd on ce when exe=1, and hold it otherwise; latency is one ce cycle.
REQ-018 SHALL capture dstd into dstdpt and mtx_dover into mtx_doverp on every ce.
REQ-019 SHALL drive dstdp as mem_data when mtx_doverp=1, and as dstdpt otherwise; mem_data passes combinationally.
REQ-020 SHALL keep a 2^AW-bit pending vector: on ce, ld_issue=1 sets pending[ld_addr] and ld_done=1 clears pending[ld_done_addr].
REQ-021 SHALL let set win when a set and a clear target the same address in one ce cycle.
REQ-022 SHALL drive src_busy = pending[srca] & ~locden, dst_busy = pending[dsta], and any_pending = OR of the pending vector, all combinationally from current state.
REQ-023 SHALL hold all state when ce=0, ignoring every write, set and clear request.
REQ-024 SHALL require no wrap-around handling, since all address arithmetic is modulo 2^AW by width.

Reset
REQ-025 SHALL, when reset_n=0, asynchronously clear srcdp, dstdpt, mtx_doverp and the pending vector; srcdp, dstdp, src_busy, dst_busy and any_pending therefore read 0 (dstdp is 0 provided mtx_doverp is 0).
REQ-026 SHALL leave register array contents unreset, so reads before the first write are undefined.
REQ-027 SHALL, when reset is asserted mid-operation, drop all pending loads, and SHALL ignore any ld_done that arrives after reset release for a cleared entry.

Structure
REQ-028 SHALL take the default DW/AW constants and the srcd/dstd mux select encodings from the shared package regfile_pkg.
REQ-029 SHALL implement storage in one sub-module, regfile_ram, a 2-read/2-write array with dst-wins collision that is written on sys_clk&ce.
REQ-030 SHALL keep the bypass muxes, pipeline registers and scoreboard in regfile_bypass.

Verification
REQ-031 SHALL verify write reg[5]=0x12345678 via the dst port, then read srca=5 -> srcd=0x12345678 on the following cycle.
REQ-032 SHALL verify same-cycle dst write 0xAAAA0000 to addr 3 with srca=3 and srcwen_n=1 -> srcd=0xAAAA0000 in that cycle, with locden=1 and locsrc=0x55 -> srcd=0x55.
REQ-033 SHALL verify both ports writing addr 7 (src 0x1, dst 0x2) -> reg[7]=0x2 on the next read.
REQ-034 SHALL verify exe=0 holds srcdp across 3 ce cycles, and mtx_dover=1 with mem_data=0xDEAD -> dstdp=0xDEAD one ce later.
REQ-035 SHALL verify ld_issue addr 9 -> dst_busy=1 when dsta=9; ld_issue and ld_done on addr 9 in the same cycle -> stays busy; ld_done alone -> busy 0 and any_pending=0.
REQ-036 SHALL verify reset_n asserted with 4 pending entries and srcdp=0xFFFFFFFF -> any_pending=0 and srcdp=0 immediately, without waiting for a clock.
